// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   MODE_ADD / MODE_SUB : encoding of the 'sub' mode input
//   chunk_width()       : bits handled per pipeline stage
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int chunk_width(input int n, input int stages);
    return (stages <= 0) ? n : n / stages;
  endfunction

endpackage

// File: rtl/pipe_chunk_adder.sv
// Combinational W-bit adder slice with carry in/out.
//   a, b : W-bit operands
//   cin  : carry into the slice
//   sum  : W-bit result
//   cout : carry out of the slice
module pipe_chunk_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  end

endmodule

// File: rtl/pipe_addsub_nbit.sv
// Pipelined N-bit adder/subtractor, one W = N/STAGES bit chunk per stage,
// with a valid/ready handshake on both sides.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake (a, b, cin, sub sampled on transfer)
//   a, b                : operands
//   cin                 : carry-in (add) / borrow-in (subtract)
//   sub                 : 0 = add, 1 = subtract
//   out_valid/out_ready : output handshake
//   sum, cout, ovf      : result, carry-out (subtract: 1 = no borrow), signed overflow
module pipe_addsub_nbit
  import addsub_pkg::*;
#(
  parameter int N      = 16,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int W = chunk_width(N, STAGES);

  if (STAGES < 1 || (N % STAGES) != 0) begin : g_param_check
    $error("pipe_addsub_nbit: STAGES must be >= 1 and divide N");
  end

  logic         adv;
  logic [N-1:0] b_eff;
  logic         c_eff;

  // The whole pipeline moves as one unit; a stalled output freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    b_eff = (sub == MODE_ADD) ? b : ~b;
    c_eff = (sub == MODE_SUB) ? ~cin : cin;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still unconsumed when entering this stage, and bits kept
    // after it. The last stage keeps only the operand sign bits for ovf.
    localparam int IW = N - k * W;
    localparam int OW = (k < STAGES - 1) ? IW - W : 1;

    logic [IW-1:0]        a_in, b_in;
    logic                 c_in, v_in;
    logic [(k+1)*W-1:0]   s_nxt, s_q;
    logic [W-1:0]         chunk_s;
    logic                 chunk_c;
    logic [OW-1:0]        a_nxt, b_nxt, a_q, b_q;
    logic                 c_q, v_q;

    if (k == 0) begin : g_first
      assign a_in  = a;
      assign b_in  = b_eff;
      assign c_in  = c_eff;
      assign v_in  = in_valid;
      assign s_nxt = chunk_s;
    end else begin : g_next
      assign a_in  = g_stage[k-1].a_q;
      assign b_in  = g_stage[k-1].b_q;
      assign c_in  = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
      assign s_nxt = {chunk_s, g_stage[k-1].s_q};
    end

    if (k < STAGES - 1) begin : g_mid
      assign a_nxt = a_in[IW-1:W];
      assign b_nxt = b_in[IW-1:W];
    end else begin : g_last
      assign a_nxt = a_in[IW-1];
      assign b_nxt = b_in[IW-1];
    end

    pipe_chunk_adder #(.W(W)) u_add (
      .a    (a_in[W-1:0]),
      .b    (b_in[W-1:0]),
      .cin  (c_in),
      .sum  (chunk_s),
      .cout (chunk_c)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
        a_q <= '0;
        b_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= chunk_c;
        s_q <= s_nxt;
        a_q <= a_nxt;
        b_q <= b_nxt;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
  // Overflow from the registered sign bits of a and b_eff; all clear after reset.
  assign ovf       = (g_stage[STAGES-1].a_q == g_stage[STAGES-1].b_q) &&
                     (sum[N-1] != g_stage[STAGES-1].a_q[0]);

endmodule

// File: tb/tb_pipe_addsub_nbit.sv
module tb_pipe_addsub_nbit;

  localparam int N      = 16;
  localparam int STAGES = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [N-1:0]  a, b, sum;

  always #5 clk = ~clk;

  pipe_addsub_nbit #(.N(N), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    res_t        exp;
  } vec_t;

  int   nvec = 0;
  int   nerr = 0;
  int   out_count = 0;
  res_t exp_q[$];
  res_t cur_exp;
  logic acc, oxf, s_in_ready, s_out_valid, hold_chk;
  res_t s_res, hold_res, front;
  vec_t tbl[10];
  int   lat, issued, base, cnt0;

  // Reference: plain integer arithmetic on the mathematical values.
  function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mcin, input logic msub);
    int   r, sr, sa, sb;
    res_t o;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (msub) begin
      r      = int'(ma) - int'(mb) - int'(mcin);
      sr     = sa - sb - int'(mcin);
      o.cout = (r >= 0);
    end else begin
      r      = int'(ma) + int'(mb) + int'(mcin);
      sr     = sa + sb + int'(mcin);
      o.cout = (r > 65535);
    end
    o.sum = r[15:0];
    o.ovf = (sr > 32767) || (sr < -32768);
    return o;
  endfunction

  function automatic vec_t mk(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                              input logic vs, input logic [15:0] es, input logic ec, input logic eo);
    vec_t v;
    v.a = va; v.b = vb; v.cin = vc; v.sub = vs;
    v.exp.sum = es; v.exp.cout = ec; v.exp.ovf = eo;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] da, input logic [15:0] db, input logic dc,
                       input logic ds, input res_t e);
    a = da; b = db; cin = dc; sub = ds; cur_exp = e;
  endtask

  // One clock cycle: sample at the falling edge, score transfers, step past the rising edge.
  task automatic tick();
    @(negedge clk);
    acc         = in_valid && in_ready;
    oxf         = out_valid && out_ready;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_res       = {sum, cout, ovf};
    if (!rst) begin
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (hold_chk) begin
        check("hold_valid", out_valid, 1);
        check("hold_result", s_res, hold_res);
      end
      if (acc) exp_q.push_back(cur_exp);
      if (oxf) begin
        out_count++;
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_output: got %h expected none", s_res);
        end else begin
          front = exp_q.pop_front();
          check("result", s_res, front);
        end
      end
      hold_chk = out_valid && !out_ready;
      hold_res = s_res;
    end else begin
      hold_chk = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    hold_chk = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic drive_random();
    logic [15:0] ra, rb;
    logic        rc, rs;
    ra = 16'($urandom);
    rb = 16'($urandom);
    rc = 1'($urandom);
    rs = 1'($urandom);
    drive(ra, rb, rc, rs, model(ra, rb, rc, rs));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; hold_chk = 1'b0; cur_exp = '0;

    tbl[0] = mk(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    tbl[1] = mk(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    tbl[2] = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    tbl[3] = mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    tbl[4] = mk(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    tbl[5] = mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    tbl[6] = mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    tbl[7] = mk(16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    tbl[8] = mk(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    tbl[9] = mk(16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0);

    @(posedge clk);
    #1;
    do_reset();

    // Reset state, first cycle after release
    tick();
    check("reset_out_valid", s_out_valid, 0);
    check("reset_result", s_res, 0);
    check("reset_in_ready", s_in_ready, 1);

    // Single-bundle latency
    drive(tbl[0].a, tbl[0].b, tbl[0].cin, tbl[0].sub, tbl[0].exp);
    in_valid = 1'b1;
    tick();
    check("accept_first", acc, 1);
    in_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (oxf && lat == 0) lat = c;
    end
    check("latency", lat, STAGES);

    // Table vectors, back to back
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].exp);
      in_valid = 1'b1;
      tick();
    end
    drain();

    // 8 bundles with the output stalled in cycles 6-8
    do_reset();
    issued = 0;
    base   = out_count;
    for (int c = 0; c < 20; c++) begin
      in_valid  = (issued < 8);
      out_ready = !(c >= 6 && c <= 8);
      drive_random();
      tick();
      if (acc) issued++;
      if (c >= 6 && c <= 8) begin
        check("stall_in_ready", s_in_ready, 0);
        check("stall_out_valid", s_out_valid, 1);
      end
    end
    drain();
    check("stall_issued", issued, 8);
    check("stall_out_count", out_count - base, 8);

    // Reset with three bundles in flight
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_random();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    hold_chk = 1'b0;
    cnt0 = out_count;
    tick();
    check("rst_flush_valid", s_out_valid, 0);
    for (int i = 0; i < 10; i++) tick();
    check("rst_flush_count", out_count - cnt0, 0);

    // Random traffic against the reference model
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive_random();
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
